div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
- Arbitration and sequencing controller that shares one multi-cycle 64/32 unsigned divider core between two requesters (port 0, port 1).
- Round-robin grant, one transaction in flight.
- Drives the core with a one-cycle start pulse and captures its quotient/remainder on done.
- Returns results with a valid/ready handshake and error flags: overflow, divide-by-zero, timeout.

Parameters:
- TIMEOUT, 80, maximum cycles in WAIT before the transaction is aborted with err_to.
- CNT_W, 7, width of the WAIT cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a division pending.
- req0_a  in  64  requester 0 dividend.
- req0_b  in  32  requester 0 divisor.
- req0_ready  out  1  request 0 accepted this cycle.
- req1_valid / req1_a / req1_b / req1_ready: same as port 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_id  out  1  requester that owns the response.
- rsp_q  out  32  quotient.
- rsp_r  out  32  remainder.
- rsp_err  out  3  {err_to, err_dz, err_ovf}.
- rsp_ready  in  1  consumer accepts the response.
- div_start  out  1  one-cycle start pulse to the divider core.
- div_a  out  64  operand A to the core; held stable from start until done.
- div_b  out  32  operand B to the core; held stable from start until done.
- div_done  in  1  core result valid; one-cycle pulse.
- div_q  in  32  core quotient.
- div_r  in  32  core remainder.
- busy  out  1  controller not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all outputs are 0, including div_a, div_b, rsp_q, rsp_r, rsp_err and rsp_id.
  - Round-robin pointer rr=0, meaning port 0 has priority on the next tie.
  - Reset mid-transaction discards the transaction; a later div_done is ignored.
- State IDLE:
  - With no request pending, stay in IDLE.
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant port rr, then set rr to the other port.
  - On grant:
    - Pulse reqN_ready high for that single cycle; the other ready stays 0.
    - Latch a, b and id into internal registers.
    - Compute err_ovf = (a[63:32] >= b) and err_dz = (b == 0).
  - If err_dz or err_ovf is set, go to RESP without starting the core:
    - rsp_q = 32'hFFFFFFFF; rsp_r = a[31:0].
  - Otherwise go to ISSUE.
- State ISSUE (1 cycle):
  - div_start=1; div_a and div_b driven from the latched operands.
  - Clear the WAIT counter; go to WAIT.
- State WAIT:
  - Counter increments every cycle.
  - If div_done=1: capture div_q/div_r into rsp_q/rsp_r; err=0; go to RESP.
  - Else, if the counter reaches TIMEOUT: rsp_q=0, rsp_r=0, err_to=1; go to RESP.
  - If div_done and the timeout coincide, done wins and err_to=0.
  - div_done outside WAIT is ignored.
- State RESP:
  - rsp_valid=1; rsp_id, rsp_q, rsp_r and rsp_err are stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE.
  - rsp_valid drops in the next cycle; rsp_* hold their last value.
- Latency:
  - Normal transaction: grant-to-rsp_valid = 2 + core latency (cycles from start to done).
  - Error bypass: grant-to-rsp_valid = 1 cycle.
- Requests are not accepted in ISSUE/WAIT/RESP: both ready outputs are 0.
- Requesters must hold valid and operands until ready.
- busy = (state != IDLE).

Optional Feature:
- Macro DIV_SHARE_STATS_EN.
- When defined, adds three outputs:
  - stat_cnt0 (16 bits): completed transactions for port 0.
  - stat_cnt1 (16 bits): completed transactions for port 1.
  - stat_err (16 bits): transactions with any err bit set.
- Counters increment on the rsp_valid & rsp_ready cycle, saturate at 16'hFFFF, and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single request: port 0, a=64'd100, b=32'd7; core done after 66 cycles → one div_start pulse, rsp_q=14, rsp_r=2, rsp_id=0, rsp_err=0.
- Simultaneous requests from both ports, after reset → port 0 served first, then port 1. Repeat the simultaneous request → port 1 granted first, confirming round-robin alternation.
- Divide by zero: b=0, a=64'h5 → no div_start, rsp_q=32'hFFFFFFFF, rsp_r=5, rsp_err=3'b010, rsp_valid one cycle after grant.
- Overflow: a=64'h0000_0002_0000_0000, b=2 → no div_start, rsp_err=3'b001.
- Core never asserts done → rsp_valid after TIMEOUT cycles in WAIT with rsp_err=3'b100, rsp_q=0. A div_done asserted later, while in IDLE, is ignored.
- Backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles → rsp_* stable, both ready outputs 0; the response completes on the rsp_ready cycle.
  - Assert rst_n=0 during WAIT → all outputs 0 immediately; the next request is served normally.

Source files
------------

// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_share_ctrl
// Purpose  : Shares one multi-cycle 64/32 unsigned divider core between two
//            requesters. Round-robin arbitration, one transaction in flight.
//            Operands that would overflow a 32-bit quotient or divide by zero
//            are answered directly without starting the core. A transaction
//            whose core never reports done is aborted after TIMEOUT cycles.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            req{0,1}_valid/a/b  - requester operands, held until ready
//            req{0,1}_ready      - single-cycle accept pulse
//            rsp_valid/ready     - response handshake
//            rsp_id/q/r/err      - owner, quotient, remainder, {to, dz, ovf}
//            div_start/a/b       - start pulse and operands to the core
//            div_done/q/r        - core completion pulse and result
//            busy                - controller not idle
//            stat_cnt0/1, stat_err (DIV_SHARE_STATS_EN only) - saturating
//                                  completion and error counters
// Options  : define DIV_SHARE_STATS_EN to add the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module div_share_ctrl #(
  parameter int TIMEOUT = 80,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [63:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_q,
  output logic [31:0] rsp_r,
  output logic [2:0]  rsp_err,
  input  logic        rsp_ready,
  output logic        div_start,
  output logic [63:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        busy
`ifdef DIV_SHARE_STATS_EN
  ,
  output logic [15:0] stat_cnt0,
  output logic [15:0] stat_cnt1,
  output logic [15:0] stat_err
`endif
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_wait  = 2'd2;
  localparam logic [1:0] c_resp  = 2'd3;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  logic [1:0]       r_state;
  logic             r_rr;
  logic             r_id;
  logic [63:0]      r_a;
  logic [31:0]      r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_id;
  logic [31:0]      r_rsp_q;
  logic [31:0]      r_rsp_r;
  logic [2:0]       r_rsp_err;

  logic             w_grant;
  logic             w_sel;
  logic [63:0]      w_a;
  logic [31:0]      w_b;
  logic             w_dz;
  logic             w_ovf;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_timeout;

  // Port 1 wins when it is the only requester or when both request and the
  // round-robin pointer favours it.
  assign w_sel   = req1_valid & (~req0_valid | r_rr);
  // Gating with rst_n keeps the combinational ready outputs low during reset.
  assign w_grant = rst_n & (r_state == c_idle) & (req0_valid | req1_valid);
  assign w_a     = w_sel ? req1_a : req0_a;
  assign w_b     = w_sel ? req1_b : req0_b;

  // A zero divisor reports only divide-by-zero, even though the high word
  // trivially compares >= 0.
  assign w_dz  = (w_b == 32'd0);
  assign w_ovf = ~w_dz & (w_a[63:32] >= w_b);

  // The WAIT phase lasts at most TIMEOUT cycles: the counter starts at zero
  // on the first WAIT cycle and the abort fires when its next value hits
  // TIMEOUT.
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_timeout = (w_cnt_nxt == c_timeout);

  assign req0_ready = w_grant & ~w_sel;
  assign req1_ready = w_grant & w_sel;
  assign div_start  = (r_state == c_issue);
  assign div_a      = r_a;
  assign div_b      = r_b;
  assign rsp_valid  = (r_state == c_resp);
  assign rsp_id     = r_rsp_id;
  assign rsp_q      = r_rsp_q;
  assign rsp_r      = r_rsp_r;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != c_idle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_idle;
      r_rr      <= 1'b0;
      r_id      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_rsp_id  <= 1'b0;
      r_rsp_q   <= '0;
      r_rsp_r   <= '0;
      r_rsp_err <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_grant) begin
            r_a  <= w_a;
            r_b  <= w_b;
            r_id <= w_sel;
            // The pointer only moves on a genuine tie.
            if (req0_valid && req1_valid) r_rr <= ~r_rr;
            if (w_dz || w_ovf) begin
              r_rsp_id  <= w_sel;
              r_rsp_q   <= '1;
              r_rsp_r   <= w_a[31:0];
              r_rsp_err <= {1'b0, w_dz, w_ovf};
              r_state   <= c_resp;
            end else begin
              r_state <= c_issue;
            end
          end
        end
        c_issue: begin
          r_cnt   <= '0;
          r_state <= c_wait;
        end
        c_wait: begin
          r_cnt <= w_cnt_nxt;
          // done is checked first so it wins over a coincident timeout.
          if (div_done) begin
            r_rsp_id  <= r_id;
            r_rsp_q   <= div_q;
            r_rsp_r   <= div_r;
            r_rsp_err <= 3'b000;
            r_state   <= c_resp;
          end else if (w_timeout) begin
            r_rsp_id  <= r_id;
            r_rsp_q   <= '0;
            r_rsp_r   <= '0;
            r_rsp_err <= 3'b100;
            r_state   <= c_resp;
          end
        end
        c_resp: begin
          if (rsp_ready) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef DIV_SHARE_STATS_EN
  logic        w_hs;
  logic [15:0] r_stat_cnt0;
  logic [15:0] r_stat_cnt1;
  logic [15:0] r_stat_err;

  assign w_hs      = rsp_valid & rsp_ready;
  assign stat_cnt0 = r_stat_cnt0;
  assign stat_cnt1 = r_stat_cnt1;
  assign stat_err  = r_stat_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_cnt0 <= '0;
      r_stat_cnt1 <= '0;
      r_stat_err  <= '0;
    end else if (w_hs) begin
      if (!r_rsp_id && r_stat_cnt0 != 16'hFFFF) r_stat_cnt0 <= r_stat_cnt0 + 16'd1;
      if (r_rsp_id && r_stat_cnt1 != 16'hFFFF)  r_stat_cnt1 <= r_stat_cnt1 + 16'd1;
      if ((|r_rsp_err) && r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_ctrl
// Purpose  : Self-checking bench for div_share_ctrl. A behavioural divider
//            core answers start pulses after a programmable latency; expected
//            responses come from an arithmetic reference model of the
//            arbitration, error and timeout rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_share_ctrl;

  localparam int TIMEOUT = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [63:0] req0_a = '0, req1_a = '0;
  logic [31:0] req0_b = '0, req1_b = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_q, rsp_r;
  logic [2:0]  rsp_err;
  logic        rsp_ready = 1'b0;
  logic        div_start;
  logic [63:0] div_a;
  logic [31:0] div_b;
  logic        div_done = 1'b0;
  logic [31:0] div_q = '0, div_r = '0;
  logic        busy;
`ifdef DIV_SHARE_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, stat_err;
`endif

  div_share_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .busy(busy)
`ifdef DIV_SHARE_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  bit m_rr = 1'b0;

  // Behavioural divider core: done arrives core_lat cycles after the start
  // cycle; core_lat == 0 means the core never answers.
  int core_lat = 0;
  int core_rem = 0;
  int start_cnt = 0;
  int inject_req = 0;
  int inject_ack = 0;
  logic [63:0] core_qq, core_rm;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (inject_req != inject_ack) begin
      inject_ack = inject_req;
      div_done = 1'b1;
      div_q = 32'hDEAD_BEEF;
      div_r = 32'h1234_5678;
    end
    if (core_rem > 0) begin
      core_rem = core_rem - 1;
      if (core_rem == 0) begin
        div_done = 1'b1;
        if (div_b != 32'd0) begin
          core_qq = div_a / {32'd0, div_b};
          core_rm = div_a % {32'd0, div_b};
        end else begin
          core_qq = '1;
          core_rm = '0;
        end
        div_q = core_qq[31:0];
        div_r = core_rm[31:0];
      end
    end
    if (div_start) begin
      start_cnt = start_cnt + 1;
      core_rem = core_lat;
    end
  end

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [2:0]  err;
    int          lat;
    int          starts;
  } exp_t;

  // Reference model: result, error code, grant-to-valid latency and number of
  // core starts for one transaction.
  function automatic exp_t model(input logic [63:0] a, input logic [31:0] b, input int lat);
    exp_t e;
    logic [63:0] qq, rm;
    if (b == 32'd0) begin
      e.q = '1; e.r = a[31:0]; e.err = 3'b010; e.lat = 1; e.starts = 0;
    end else if (a[63:32] >= b) begin
      e.q = '1; e.r = a[31:0]; e.err = 3'b001; e.lat = 1; e.starts = 0;
    end else if (lat < 1 || lat > TIMEOUT) begin
      e.q = '0; e.r = '0; e.err = 3'b100; e.lat = TIMEOUT + 2; e.starts = 1;
    end else begin
      qq = a / {32'd0, b};
      rm = a % {32'd0, b};
      e.q = qq[31:0]; e.r = rm[31:0]; e.err = 3'b000; e.lat = lat + 2; e.starts = 1;
    end
    return e;
  endfunction

  function automatic void gen_ops(input bit allow_err, output logic [63:0] a, output logic [31:0] b);
    int sel;
    logic [31:0] hi;
    sel = allow_err ? int'($urandom_range(0, 9)) : 9;
    b = $urandom;
    if (sel >= 5) b = b >> $urandom_range(0, 31);
    if (b == 32'd0) b = 32'd1;
    case (sel)
      0:       begin b = 32'd0; hi = $urandom; end
      1:       hi = b;
      2:       hi = $urandom | b;
      3:       hi = b - 32'd1;
      default: hi = $urandom % b;
    endcase
    a = {hi, 32'($urandom)};
  endfunction

  // Observations filled by the driver tasks.
  bit          obs_gok, obs_gid, obs_rok, obs_rid;
  int          obs_gcyc, obs_rcyc;
  logic [31:0] obs_q, obs_r;
  logic [2:0]  obs_err;

  // Driver tasks start and end just after a falling edge.
  task automatic wait_grant();
    obs_gok = 1'b0; obs_gid = 1'b0; obs_gcyc = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        obs_gok = 1'b1; obs_gid = req1_ready; obs_gcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (obs_gok) begin
      if (obs_gid) req1_valid = 1'b0; else req0_valid = 1'b0;
    end else begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    obs_rok = 1'b0; obs_rcyc = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (rsp_valid) begin
        obs_rok = 1'b1; obs_rcyc = cyc;
        obs_rid = rsp_id; obs_q = rsp_q; obs_r = rsp_r; obs_err = rsp_err;
        break;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_rr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready, busy, rsp_valid, div_start} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b exp 00000", {req0_ready, req1_ready, busy, rsp_valid, div_start});
    end
    n_vec++;
    if ({div_a, div_b} !== 96'd0) begin
      n_err++; $display("FAIL reset_div_ops: got %h exp 0", {div_a, div_b});
    end
    n_vec++;
    if ({rsp_id, rsp_q, rsp_r, rsp_err} !== 68'd0) begin
      n_err++; $display("FAIL reset_rsp: got %h exp 0", {rsp_id, rsp_q, rsp_r, rsp_err});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 1'b0;
  endtask

  task automatic test_single();
    int s0;
    @(negedge clk);
    core_lat = 66; s0 = start_cnt;
    req0_a = 64'd100; req0_b = 32'd7; req0_valid = 1'b1;
    wait_grant();
    wait_rsp();
    n_vec++;
    if (!obs_gok || !obs_rok || obs_gid !== 1'b0) begin
      n_err++; $display("FAIL single_hs: got grant_ok=%0d rsp_ok=%0d gid=%0d exp 1 1 0", obs_gok, obs_rok, obs_gid);
    end
    n_vec++;
    if ({obs_rid, obs_q, obs_r, obs_err} !== {1'b0, 32'd14, 32'd2, 3'b000}) begin
      n_err++; $display("FAIL single_rsp: got id=%0d q=%0d r=%0d err=%b exp 0 14 2 000", obs_rid, obs_q, obs_r, obs_err);
    end
    n_vec++;
    if (obs_rcyc - obs_gcyc !== 68 || start_cnt - s0 !== 1) begin
      n_err++; $display("FAIL single_timing: got lat=%0d starts=%0d exp 68 1", obs_rcyc - obs_gcyc, start_cnt - s0);
    end
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_q !== 32'd14) begin
      n_err++; $display("FAIL single_after: got valid=%0d q=%0d exp 0 14", rsp_valid, rsp_q);
    end
  endtask

  task automatic test_rr();
    logic [63:0] a0, a1; logic [31:0] b0, b1;
    bit p0, p1; int eid, lat; exp_t e;
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      gen_ops(1'b0, a0, b0); gen_ops(1'b0, a1, b1);
      lat = $urandom_range(1, 10); core_lat = lat;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_valid = 1'b1; req1_valid = 1'b1; p0 = 1'b1; p1 = 1'b1;
      for (int k = 0; k < 2; k++) begin
        wait_grant();
        eid = (p0 && p1) ? int'(m_rr) : (p1 ? 1 : 0);
        if (p0 && p1) m_rr = ~m_rr;
        if (eid == 1) p1 = 1'b0; else p0 = 1'b0;
        e = (eid == 1) ? model(a1, b1, lat) : model(a0, b0, lat);
        wait_rsp();
        n_vec++;
        if (!obs_gok || int'(obs_gid) !== eid) begin
          n_err++; $display("FAIL rr_grant r%0d k%0d: got ok=%0d id=%0d exp id=%0d", round, k, obs_gok, obs_gid, eid);
        end
        n_vec++;
        if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {eid[0], e.q, e.r, e.err} || obs_rcyc - obs_gcyc !== e.lat) begin
          n_err++; $display("FAIL rr_rsp r%0d k%0d: got id=%0d q=%h r=%h err=%b lat=%0d exp %0d %h %h %b %0d",
                            round, k, obs_rid, obs_q, obs_r, obs_err, obs_rcyc - obs_gcyc, eid, e.q, e.r, e.err, e.lat);
        end
      end
    end
  endtask

  task automatic test_dz();
    int s0;
    @(negedge clk);
    s0 = start_cnt; core_lat = 5;
    req1_a = 64'h5; req1_b = 32'd0; req1_valid = 1'b1;
    wait_grant();
    wait_rsp();
    n_vec++;
    if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {1'b1, 32'hFFFF_FFFF, 32'd5, 3'b010}) begin
      n_err++; $display("FAIL dz_rsp: got id=%0d q=%h r=%0d err=%b exp 1 ffffffff 5 010", obs_rid, obs_q, obs_r, obs_err);
    end
    n_vec++;
    if (obs_rcyc - obs_gcyc !== 1 || start_cnt - s0 !== 0) begin
      n_err++; $display("FAIL dz_timing: got lat=%0d starts=%0d exp 1 0", obs_rcyc - obs_gcyc, start_cnt - s0);
    end
  endtask

  task automatic test_ovf();
    int s0;
    @(negedge clk);
    s0 = start_cnt; core_lat = 5;
    req0_a = 64'h0000_0002_0000_0000; req0_b = 32'd2; req0_valid = 1'b1;
    wait_grant();
    wait_rsp();
    n_vec++;
    if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {1'b0, 32'hFFFF_FFFF, 32'd0, 3'b001}) begin
      n_err++; $display("FAIL ovf_rsp: got id=%0d q=%h r=%0d err=%b exp 0 ffffffff 0 001", obs_rid, obs_q, obs_r, obs_err);
    end
    n_vec++;
    if (obs_rcyc - obs_gcyc !== 1 || start_cnt - s0 !== 0) begin
      n_err++; $display("FAIL ovf_timing: got lat=%0d starts=%0d exp 1 0", obs_rcyc - obs_gcyc, start_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    int s0, lats[3];
    bit seen;
    exp_t e;
    lats[0] = 0; lats[1] = TIMEOUT; lats[2] = TIMEOUT + 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s0 = start_cnt; core_lat = lats[k];
      req1_a = 64'd1000 + 64'(k); req1_b = 32'd3; req1_valid = 1'b1;
      e = model(64'd1000 + 64'(k), 32'd3, lats[k]);
      wait_grant();
      wait_rsp();
      n_vec++;
      if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {1'b1, e.q, e.r, e.err}) begin
        n_err++; $display("FAIL to_rsp lat%0d: got id=%0d q=%0d r=%0d err=%b exp 1 %0d %0d %b",
                          lats[k], obs_rid, obs_q, obs_r, obs_err, e.q, e.r, e.err);
      end
      n_vec++;
      if (obs_rcyc - obs_gcyc !== e.lat || start_cnt - s0 !== 1) begin
        n_err++; $display("FAIL to_timing lat%0d: got lat=%0d starts=%0d exp %0d 1", lats[k], obs_rcyc - obs_gcyc, start_cnt - s0, e.lat);
      end
      if (k == 0) begin
        inject_req = inject_req + 1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk); #1;
          if (rsp_valid || busy) seen = 1'b1;
        end
        n_vec++;
        if (seen || rsp_err !== 3'b100) begin
          n_err++; $display("FAIL to_late_done: got activity=%0d err=%b exp 0 100", seen, rsp_err);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a0, a1; logic [31:0] b0, b1;
    exp_t e0, e1; bit bad; int g;
    @(negedge clk);
    gen_ops(1'b0, a0, b0); gen_ops(1'b0, a1, b1);
    core_lat = 4;
    e0 = model(a0, b0, 4); e1 = model(a1, b1, 4);
    req0_a = a0; req0_b = b0; req0_valid = 1'b1;
    wait_grant();
    req1_a = a1; req1_b = b1; req1_valid = 1'b1;
    g = obs_gcyc;
    for (int i = 0; i < 50 && !rsp_valid; i++) begin
      @(negedge clk); #1;
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || req0_ready || req1_ready || {rsp_id, rsp_q, rsp_r, rsp_err} !== {1'b0, e0.q, e0.r, e0.err}) bad = 1'b1;
      @(negedge clk); #1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL bp_hold: got valid=%0d id=%0d q=%h r=%h err=%b exp 1 0 %h %h %b",
                        rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, e0.q, e0.r, e0.err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || cyc - g !== e0.lat + 11) begin
      n_err++; $display("FAIL bp_release: got valid=%0d ready1=%0d dt=%0d exp 0 1 %0d", rsp_valid, req1_ready, cyc - g, e0.lat + 11);
    end
    wait_grant();
    wait_rsp();
    n_vec++;
    if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {1'b1, e1.q, e1.r, e1.err}) begin
      n_err++; $display("FAIL bp_second: got id=%0d q=%h r=%h err=%b exp 1 %h %h %b", obs_rid, obs_q, obs_r, obs_err, e1.q, e1.r, e1.err);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a; logic [31:0] b; exp_t e; bit seen;
    @(negedge clk);
    core_lat = 66;
    req0_a = 64'd123456; req0_b = 32'd11; req0_valid = 1'b1;
    wait_grant();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, rsp_valid, div_start, req0_ready, req1_ready, rsp_id, rsp_q, rsp_r, rsp_err, div_a, div_b} !== '0) begin
      n_err++; $display("FAIL rstmid_outs: got busy=%0d valid=%0d div_a=%h rsp_q=%h exp all 0", busy, rsp_valid, div_a, rsp_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++; $display("FAIL rstmid_stale_done: got activity=1 exp 0");
    end
    @(negedge clk);
    gen_ops(1'b0, a, b);
    core_lat = 7; e = model(a, b, 7);
    req1_a = a; req1_b = b; req1_valid = 1'b1;
    wait_grant();
    wait_rsp();
    n_vec++;
    if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {1'b1, e.q, e.r, e.err} || obs_rcyc - obs_gcyc !== e.lat) begin
      n_err++; $display("FAIL rstmid_next: got id=%0d q=%h r=%h err=%b lat=%0d exp 1 %h %h %b %0d",
                        obs_rid, obs_q, obs_r, obs_err, obs_rcyc - obs_gcyc, e.q, e.r, e.err, e.lat);
    end
  endtask

  task automatic test_random();
    logic [63:0] a0, a1; logic [31:0] b0, b1;
    bit p0, p1; int mode, lat, s0, eid; exp_t e;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      mode = $urandom_range(0, 2);
      lat = $urandom_range(1, 12); core_lat = lat;
      gen_ops(1'b1, a0, b0); gen_ops(1'b1, a1, b1);
      p0 = (mode != 1); p1 = (mode != 0);
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      req0_valid = p0; req1_valid = p1;
      while (p0 || p1) begin
        s0 = start_cnt;
        wait_grant();
        eid = (p0 && p1) ? int'(m_rr) : (p1 ? 1 : 0);
        if (p0 && p1) m_rr = ~m_rr;
        if (eid == 1) p1 = 1'b0; else p0 = 1'b0;
        e = (eid == 1) ? model(a1, b1, lat) : model(a0, b0, lat);
        wait_rsp();
        n_vec++;
        if (!obs_gok || int'(obs_gid) !== eid) begin
          n_err++; $display("FAIL rnd_grant t%0d: got ok=%0d id=%0d exp id=%0d", t, obs_gok, obs_gid, eid);
          p0 = 1'b0; p1 = 1'b0;
        end
        n_vec++;
        if (!obs_rok || {obs_rid, obs_q, obs_r, obs_err} !== {eid[0], e.q, e.r, e.err}) begin
          n_err++; $display("FAIL rnd_rsp t%0d: got id=%0d q=%h r=%h err=%b exp %0d %h %h %b",
                            t, obs_rid, obs_q, obs_r, obs_err, eid, e.q, e.r, e.err);
        end
        n_vec++;
        if (obs_rcyc - obs_gcyc !== e.lat || start_cnt - s0 !== e.starts) begin
          n_err++; $display("FAIL rnd_timing t%0d: got lat=%0d starts=%0d exp %0d %0d",
                            t, obs_rcyc - obs_gcyc, start_cnt - s0, e.lat, e.starts);
        end
      end
    end
  endtask

`ifdef DIV_SHARE_STATS_EN
  task automatic test_stats();
    apply_reset();
    #1;
    n_vec++;
    if ({stat_cnt0, stat_cnt1, stat_err} !== 48'd0) begin
      n_err++; $display("FAIL stats_reset: got %h exp 0", {stat_cnt0, stat_cnt1, stat_err});
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      core_lat = 3;
      if (k < 3) begin
        req0_a = 64'd50; req0_b = (k == 2) ? 32'd0 : 32'd7; req0_valid = 1'b1;
      end else begin
        req1_a = 64'd50; req1_b = 32'd9; req1_valid = 1'b1;
      end
      wait_grant();
      wait_rsp();
    end
    #1;
    n_vec++;
    if ({stat_cnt0, stat_cnt1, stat_err} !== {16'd3, 16'd2, 16'd1}) begin
      n_err++; $display("FAIL stats_count: got cnt0=%0d cnt1=%0d err=%0d exp 3 2 1", stat_cnt0, stat_cnt1, stat_err);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_dz();
    test_ovf();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef DIV_SHARE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
